// File: rtl/seg7_scan_mux.sv
// Multiplexed 7-segment display scanner with double-buffered digit data.
// Loads land in a shadow register and reach the display only at frame boundaries.
module seg7_scan_mux #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter int unsigned HEX_EN         = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 0,
  parameter int unsigned AN_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int unsigned CntMax = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0]   ShowLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0]   BlankLast = CntW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(DIGITS - 1);
  localparam logic [6:0]        SegMask   = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic              DpMask    = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AnMask    = {DIGITS{AN_ACTIVE_LOW != 0}};

  typedef enum logic [0:0] {StShow, StBlank} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [IdxW-1:0]     idx_q;

  logic [4*DIGITS-1:0] shadow_value_q, active_value_q;
  logic [DIGITS-1:0]   shadow_dp_q, active_dp_q;
  logic                shadow_lz_q, active_lz_q;
  logic                pending_q;

  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q;
  logic                frame_tick_q;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'ha: g = 7'b1110111;
      4'hb: g = 7'b1111100;
      4'hc: g = 7'b0111001;
      4'hd: g = 7'b1011110;
      4'he: g = 7'b1111001;
      default: g = 7'b1110001;
    endcase
    if (HEX_EN == 0 && nib >= 4'ha) g = 7'b0000000;
    return g;
  endfunction

  logic end_show, end_blank, advance, boundary;

  always_comb begin
    end_show  = (state_q == StShow) && (cnt_q == ShowLast);
    end_blank = (state_q == StBlank) && (cnt_q == BlankLast);
    advance   = (end_show && (BLANK_CYCLES == 0)) || end_blank;
    boundary  = advance && (idx_q == IdxLast);
  end

  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              suppress;
  logic              zero_acc;
  logic [DIGITS-1:0] an_lit;
  logic [6:0]        seg_lit;

  // Walk from the most significant digit down so zero_acc means "this and all higher are zero".
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    suppress = 1'b0;
    zero_acc = 1'b1;
    an_lit   = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      zero_acc  = zero_acc & (active_value_q[4*k +: 4] == 4'h0);
      an_lit[k] = (idx_q == IdxW'(k));
      if (idx_q == IdxW'(k)) begin
        cur_nib  = active_value_q[4*k +: 4];
        cur_dp   = active_dp_q[k];
        suppress = active_lz_q && (k != 0) && zero_acc;
      end
    end
    seg_lit = suppress ? 7'b0000000 : glyph(cur_nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StShow;
      cnt_q          <= '0;
      idx_q          <= '0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_lz_q    <= 1'b0;
      active_value_q <= '0;
      active_dp_q    <= '0;
      active_lz_q    <= 1'b0;
      pending_q      <= 1'b0;
      seg_q          <= SegMask;
      dp_q           <= DpMask;
      an_q           <= AnMask;
      frame_tick_q   <= 1'b0;
    end else begin
      if (advance) begin
        state_q <= StShow;
        cnt_q   <= '0;
        idx_q   <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end else if (end_show) begin
        state_q <= StBlank;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      // Commit sees the pre-load shadow, so a load on the boundary waits one more frame.
      if (boundary) begin
        active_value_q <= shadow_value_q;
        active_dp_q    <= shadow_dp_q;
        active_lz_q    <= shadow_lz_q;
      end
      if (load) begin
        shadow_value_q <= value;
        shadow_dp_q    <= dp_in;
        shadow_lz_q    <= lz_en;
        pending_q      <= 1'b1;
      end else if (boundary) begin
        pending_q <= 1'b0;
      end

      frame_tick_q <= boundary;
      an_q         <= ((state_q == StShow) ? an_lit : '0) ^ AnMask;
      seg_q        <= ((state_q == StShow) ? seg_lit : 7'b0000000) ^ SegMask;
      dp_q         <= ((state_q == StShow) ? cur_dp : 1'b0) ^ DpMask;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- DIGITS, 4, number of digits; legal range 1..8.
- REFRESH_DIV, 50000, clk cycles each digit is lit; minimum 2.
- BLANK_CYCLES, 16, all-anodes-off guard cycles after each digit; 0 means no guard phase.
- HEX_EN, 1, 1 = nibbles 10..15 show A,b,C,d,E,F; 0 = nibbles 10..15 are blank.
- SEG_ACTIVE_LOW, 0, 1 = seg and dp outputs are inverted.
- AN_ACTIVE_LOW, 0, 1 = an output is inverted.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic is on the rising edge.
- rst, in, 1, synchronous active-high reset.
- load, in, 1, one-cycle strobe that captures value, dp_in and lz_en.
- value, in, 4*DIGITS, packed nibbles; digit k uses value[4k+3:4k]; digit 0 is least significant.
- dp_in, in, DIGITS, decimal point enable per digit.
- lz_en, in, 1, leading-zero suppression enable.
- seg, out, 7, segments; bit0..bit6 = a,b,c,d,e,f,g; active-high when SEG_ACTIVE_LOW=0.
- dp, out, 1, decimal point for the currently lit digit.
- an, out, DIGITS, one-hot digit enable.
- pending, out, 1, high while a captured load is waiting for the frame boundary.
- frame_tick, out, 1, one-cycle pulse at each frame boundary.

Function
REQ-003 SHALL hold a shadow register and an active register, each of 4*DIGITS + DIGITS + 1 bits (value, dp, lz).
REQ-004 SHALL, when load=1, write the inputs into the shadow register and set pending=1.
- A load while pending=1 overwrites the shadow register; the last load wins.
REQ-005 SHALL copy shadow to active and clear pending only at a frame boundary, so the display never tears mid-frame.
REQ-006 SHALL, when load=1 on a frame-boundary cycle, commit the old shadow contents, capture the new inputs into shadow, and keep pending=1.
REQ-007 SHALL use a scan FSM with states SHOW and BLANK, a cycle counter cnt, and a digit index idx (0..DIGITS-1).
REQ-008 SHOW transitions:
- SHOW lasts REFRESH_DIV cycles (cnt 0..REFRESH_DIV-1).
- At the end of SHOW, go to BLANK if BLANK_CYCLES>0; otherwise advance idx directly.
REQ-009 BLANK transitions:
- BLANK lasts BLANK_CYCLES cycles.
- At the end of BLANK, advance idx; idx DIGITS-1 wraps to 0; return to SHOW with cnt=0.
REQ-010 A frame boundary SHALL be the cycle in which idx wraps from DIGITS-1 to 0.
- frame_tick=1 on exactly that registered cycle.
- Frame period = DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
REQ-011 SHALL register all outputs; an/seg/dp reflect FSM state with exactly 1 cycle of latency.
REQ-012 In SHOW: an has only bit idx asserted; seg = glyph of active nibble idx; dp = active dp[idx].
REQ-013 In BLANK: an, seg and dp SHALL all be inactive.
REQ-014 Glyphs, as seg[6:0]:
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
- 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
REQ-015 SHALL force seg=0000000 for nibbles 10..15 when HEX_EN=0; dp is unaffected.
REQ-016 SHALL, when active lz=1, blank seg for digit k>0 if nibble k and every more-significant nibble are zero.
- Digit 0 is never suppressed.
- an and dp are unaffected by suppression.
REQ-017 SHALL apply the SEG_ACTIVE_LOW and AN_ACTIVE_LOW inversions last, after all other rules, including to reset values.

Reset
REQ-018 rst=1 SHALL set, on the next edge:
- state=SHOW, cnt=0, idx=0.
- shadow=0, active=0, pending=0.
- an, seg and dp inactive; frame_tick=0.
REQ-019 rst SHALL override load and any FSM transition in the same cycle; a reset mid-frame discards pending data.
REQ-020 After rst falls, the first lit cycle SHALL show digit 0 with glyph 0 (seg=0111111) one cycle later.

Verification
Bench parameters unless stated: DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, HEX_EN=1, active-high outputs.
REQ-021 rst high 3 cycles -> an=0000, seg=0000000, dp=0, pending=0, frame_tick=0; after release, an=0001 and seg=0111111.
REQ-022 load value=16'h12AF, dp_in=0100, lz_en=0 -> pending=1 until the next frame_tick, then:
- digit0 seg=1110001.
- digit1 seg=1110111.
- digit2 seg=1011011 with dp=1.
- digit3 seg=0000110.
REQ-023 Timing check: an stays 0000 for 1 cycle between digits; frame_tick pulses every 20 cycles exactly.
REQ-024 lz_en=1, value=16'h0050 -> digits 3 and 2 have seg=0000000 with an still scanning; digit1=1101101; digit0=0111111.
- value=0 -> only digit0 shows 0111111.
REQ-025 Two loads (16'h1111, then 16'h2222) mid-frame, plus a third load on the boundary cycle:
- 16'h2222 is displayed.
- pending stays 1 after that boundary.
- pending clears at the following boundary.
REQ-026 HEX_EN=0, nibble 0xB on digit1 -> seg=0000000 on digit1. Separately, rst during digit 2 with pending=1 -> REQ-018 values on the next edge.
